// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main-control FSM: fetch/decode/execute/memory/write-back
// sequencing, memory-ready stalls, illegal-op trap and retired counter. Define MC_JR_EN to decode jr.
module mc_ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_ct_op,
  output logic [1:0]  pc_src,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
`ifdef MC_JR_EN
  localparam logic [5:0] FN_JR    = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTEXE,
    S_ALUWB,
    S_ADDIEXE,
    S_ADDIWB,
    S_BRANCH,
    S_JUMP,
`ifdef MC_JR_EN
    S_JR,
`endif
    S_ILLEGAL
  } state_t;

  typedef struct packed {
    logic       fetch;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ct_op;
    logic [1:0] pc_src;
    logic       illegal;
  } ctl_t;

  function automatic ctl_t decode_state(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:  c.alu_src_b = 2'b11;
      S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_RTEXE:   begin c.alu_src_a = 1'b1; c.alu_ct_op = 2'b10; end
      S_ALUWB:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_ADDIEXE: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB:  c.reg_write = 1'b1;
      S_BRANCH:  begin
        c.alu_src_a     = 1'b1;
        c.alu_ct_op     = 2'b01;
        c.pc_src        = 2'b01;
        c.pc_write_cond = 1'b1;
      end
      S_JUMP:    begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
`ifdef MC_JR_EN
      S_JR:      begin c.pc_src = 2'b11; c.pc_write = 1'b1; end
`endif
      S_ILLEGAL: c.illegal = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  state_t      state_q, state_d;
  ctl_t        ctl_q;
  logic [31:0] retired_q;
  logic        retire_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDIU:     state_d = S_ADDIEXE;
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            state_d = S_ILLEGAL;
            if (funct == FN_ADDU) state_d = S_RTEXE;
`ifdef MC_JR_EN
            if (funct == FN_JR)   state_d = S_JR;
`endif
          end
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTEXE:   state_d = S_ALUWB;
      S_ADDIEXE: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef MC_JR_EN
      S_JR:      state_d = S_FETCH;
`endif
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
  end

  // Every non-FETCH state that returns to FETCH is a completed instruction.
  assign retire_d = (state_d == S_FETCH) && (state_q != S_FETCH);

  // Output decode is registered from the next state; reset preloads FETCH decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      ctl_q     <= decode_state(S_FETCH);
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= decode_state(state_d);
      if (retire_d) retired_q <= retired_q + 32'd1;
    end
  end

  // Outputs are gated by rst so they drop at once when reset is asserted.
  assign ir_write   = rst & ctl_q.fetch & mem_ready;
  assign pc_en      = rst & ((ctl_q.fetch & mem_ready) | ctl_q.pc_write |
                             (ctl_q.pc_write_cond & zero));
  assign i_or_d     = rst & ctl_q.i_or_d;
  assign mem_read   = rst & ctl_q.mem_read;
  assign mem_write  = rst & ctl_q.mem_write;
  assign reg_write  = rst & ctl_q.reg_write;
  assign reg_dst    = rst & ctl_q.reg_dst;
  assign mem_to_reg = rst & ctl_q.mem_to_reg;
  assign alu_src_a  = rst & ctl_q.alu_src_a;
  assign alu_src_b  = {2{rst}} & ctl_q.alu_src_b;
  assign alu_ct_op  = {2{rst}} & ctl_q.alu_ct_op;
  assign pc_src     = {2{rst}} & ctl_q.pc_src;
  assign illegal    = rst & ctl_q.illegal;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  alu_src_b, alu_ct_op, pc_src;
  logic [31:0] retired;

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ct_op(alu_ct_op), .pc_src(pc_src),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // {pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
  //  mem_to_reg, alu_src_a, alu_src_b, alu_ct_op, pc_src, illegal}
  logic [15:0] act;
  assign act = {pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_ct_op, pc_src, illegal};

  localparam logic [15:0] E_RST        = 16'h0000;
  localparam logic [15:0] E_FETCH_RDY  = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [15:0] E_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [15:0] E_DECODE     = {9'b0,2'b11,2'b00,2'b00,1'b0};
  localparam logic [15:0] E_ADDR       = {8'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [15:0] E_MEMRD      = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,7'b0};
  localparam logic [15:0] E_MEMWB      = {5'b0,1'b1,1'b0,1'b1,1'b0,7'b0};
  localparam logic [15:0] E_MEMWR      = {1'b0,1'b0,1'b1,1'b0,1'b1,4'b0,7'b0};
  localparam logic [15:0] E_RTEXE      = {8'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
  localparam logic [15:0] E_ALUWB      = {5'b0,1'b1,1'b1,1'b0,1'b0,7'b0};
  localparam logic [15:0] E_ADDIWB     = {5'b0,1'b1,3'b0,7'b0};
  localparam logic [15:0] E_BR_T       = {1'b1,7'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [15:0] E_BR_N       = {1'b0,7'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [15:0] E_JUMP       = {1'b1,8'b0,2'b00,2'b00,2'b10,1'b0};
  localparam logic [15:0] E_JR         = {1'b1,8'b0,2'b00,2'b00,2'b11,1'b0};
  localparam logic [15:0] E_ILL        = 16'h0001;

  typedef struct {
    logic [15:0] v;
    logic [31:0] r;
    string       lbl;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;

  // Drive one cycle of inputs just after the rising edge and record what
  // the outputs must be during that cycle.
  task automatic step(input logic r, input logic rdy, input logic z,
                      input logic [15:0] ev, input logic [31:0] er, input string lbl);
    exp_t e;
    rst = r;
    mem_ready = rdy;
    zero = z;
    e.v = ev;
    e.r = er;
    e.lbl = lbl;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input string name);
    opcode = op;
    funct = fn;
    $display("instr %s opcode=%b funct=%b retired_before=%0d", name, op, fn, retired);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (act !== e.v || retired !== e.r) begin
          bad++;
          $display("FAIL %s: got ctl=%h retired=%0d, want ctl=%h retired=%0d",
                   e.lbl, act, retired, e.v, e.r);
        end
      end else if (done) begin
        if (total < 12) begin
          bad++;
          $display("FAIL too_few_checks: got %0d, want >= 12", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin : stim
    int ret;
    ret = 0;
    @(posedge clk);
    #1;
    step(0, 1, 0, E_RST, 0, "reset0");
    step(0, 1, 0, E_RST, 0, "reset1");

    instr(6'b000000, 6'b100001, "addu");
    step(1, 1, 0, E_FETCH_RDY, ret, "addu_fetch");
    step(1, 1, 0, E_DECODE,    ret, "addu_decode");
    step(1, 1, 0, E_RTEXE,     ret, "addu_rtexe");
    step(1, 1, 0, E_ALUWB,     ret, "addu_aluwb");
    ret++;

    instr(6'b100011, 6'b000000, "lw");
    step(1, 1, 0, E_FETCH_RDY, ret, "lw_fetch");
    step(1, 1, 0, E_DECODE,    ret, "lw_decode");
    step(1, 1, 0, E_ADDR,      ret, "lw_memadr");
    step(1, 0, 0, E_MEMRD,     ret, "lw_memrd_wait0");
    step(1, 0, 0, E_MEMRD,     ret, "lw_memrd_wait1");
    step(1, 1, 0, E_MEMRD,     ret, "lw_memrd_done");
    step(1, 1, 0, E_MEMWB,     ret, "lw_memwb");
    ret++;

    instr(6'b000100, 6'b000000, "beq_taken");
    step(1, 1, 1, E_FETCH_RDY, ret, "beqt_fetch");
    step(1, 1, 1, E_DECODE,    ret, "beqt_decode");
    step(1, 1, 1, E_BR_T,      ret, "beqt_branch");
    ret++;

    instr(6'b000100, 6'b000000, "beq_not_taken");
    step(1, 1, 0, E_FETCH_RDY, ret, "beqn_fetch");
    step(1, 1, 0, E_DECODE,    ret, "beqn_decode");
    step(1, 1, 0, E_BR_N,      ret, "beqn_branch");
    ret++;

    instr(6'b001001, 6'b000000, "addiu");
    step(1, 1, 0, E_FETCH_RDY, ret, "addiu_fetch");
    step(1, 1, 0, E_DECODE,    ret, "addiu_decode");
    step(1, 1, 0, E_ADDR,      ret, "addiu_exe");
    step(1, 1, 0, E_ADDIWB,    ret, "addiu_wb");
    ret++;

    instr(6'b101011, 6'b000000, "sw_reset_in_memwr");
    step(1, 1, 0, E_FETCH_RDY, ret, "swr_fetch");
    step(1, 1, 0, E_DECODE,    ret, "swr_decode");
    step(1, 1, 0, E_ADDR,      ret, "swr_memadr");
    step(1, 0, 0, E_MEMWR,     ret, "swr_memwr_ret5");
    ret = 0;
    step(0, 1, 0, E_RST,       ret, "swr_reset_abort");

    instr(6'b101011, 6'b000000, "sw_fetch_wait");
    step(1, 0, 0, E_FETCH_WAIT, ret, "sw_fetch_wait");
    step(1, 1, 0, E_FETCH_RDY,  ret, "sw_fetch");
    step(1, 1, 0, E_DECODE,     ret, "sw_decode");
    step(1, 1, 0, E_ADDR,       ret, "sw_memadr");
    step(1, 1, 0, E_MEMWR,      ret, "sw_memwr");
    ret++;

    instr(6'b000010, 6'b000000, "j");
    step(1, 1, 0, E_FETCH_RDY, ret, "j_fetch");
    step(1, 1, 0, E_DECODE,    ret, "j_decode");
    step(1, 1, 0, E_JUMP,      ret, "j_jump");
    ret++;

    instr(6'b000000, 6'b001000, "jr");
    step(1, 1, 0, E_FETCH_RDY, ret, "jr_fetch");
    step(1, 1, 0, E_DECODE,    ret, "jr_decode");
`ifdef MC_JR_EN
    step(1, 1, 0, E_JR,        ret, "jr_exec");
    ret++;
`else
    step(1, 1, 0, E_ILL,       ret, "jr_illegal0");
    step(1, 1, 0, E_ILL,       ret, "jr_illegal1");
    ret = 0;
    step(0, 1, 0, E_RST,       ret, "jr_reset");
`endif

    instr(6'b111111, 6'b000000, "illegal_op");
    step(1, 1, 0, E_FETCH_RDY, ret, "ill_fetch");
    step(1, 1, 0, E_DECODE,    ret, "ill_decode");
    for (int i = 0; i < 10; i++) step(1, 1, 1, E_ILL, ret, "ill_hold");
    ret = 0;
    step(0, 1, 0, E_RST,       ret, "ill_reset");

    instr(6'b000000, 6'b100001, "addu_after_reset");
    step(1, 1, 0, E_FETCH_RDY, ret, "addu2_fetch");
    step(1, 1, 0, E_DECODE,    ret, "addu2_decode");
    step(1, 1, 0, E_RTEXE,     ret, "addu2_rtexe");
    step(1, 1, 0, E_ALUWB,     ret, "addu2_aluwb");
    ret++;
    step(1, 0, 0, E_FETCH_WAIT, ret, "addu2_retired");
    done = 1'b1;
  end

endmodule
